// File: rtl/seq_pkg.sv
// seq_pkg: shared state encodings and default sizes for the serial pattern generator
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_RPT_W = 4;

endpackage

// File: rtl/seq_gen.sv
// seq_gen: emits a captured bit pattern MSB-first, repeated rpt+1 times, as a registered serial stream
module seq_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RPT_W = DEF_RPT_W,
    localparam int LW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic [RPT_W-1:0] rpt,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    state_t             state, state_d;
    logic [WIDTH-1:0]   pat, pat_d;
    logic [LW-1:0]      len_q, len_d, idx, idx_d;
    logic [RPT_W-1:0]   cnt, cnt_d;
    logic               out_d, valid_d, busy_d, done_d;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // captured transmission parameters and the bit-index / pass counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat   <= '0;
            len_q <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            pat   <= pat_d;
            len_q <= len_d;
            idx   <= idx_d;
            cnt   <= cnt_d;
        end
    end

    // next state: accept start in IDLE, walk the index down, reload per pass, stop aborts
    always_comb begin
        state_d = state;
        pat_d   = pat;
        len_d   = len_q;
        idx_d   = idx;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d = SHIFT;
                    pat_d   = pattern;
                    len_d   = len;
                    idx_d   = len;
                    cnt_d   = rpt;
                end
            end
            SHIFT: begin
                if (stop)          state_d = IDLE;
                else if (idx != 0) idx_d   = idx - 1'b1;
                else if (cnt != 0) begin
                    idx_d = len_q;
                    cnt_d = cnt - 1'b1;
                end else           state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from the upcoming state so they can be registered with no added latency
    always_comb begin
        valid_d = (state_d == SHIFT);
        busy_d  = (state_d == SHIFT);
        done_d  = (state_d == DONE);
        out_d   = valid_d & pat_d[idx_d];
    end

    // output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out       <= out_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed table-driven checks of seq_gen plus hand-written corner sequences
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] pattern = '0;
    logic [2:0] len = '0;
    logic [3:0] rpt = '0;
    logic       out, out_valid, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  pattern;
        logic [2:0]  len;
        logic [3:0]  rpt;
        int          stop_at;
        int          exp_n;
        logic [31:0] exp_bits;
        logic        exp_done;
    } vec_t;

    vec_t vecs[7];

    seq_gen dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .pattern(pattern), .len(len), .rpt(rpt),
        .out(out), .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // compare {busy, done, out_valid, out}
    task automatic chk(input string name, input int c, input logic [3:0] exp);
        logic [3:0] act;
        act = {busy, done, out_valid, out};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got bdvo=%b want %b", name, c, act, exp);
        end
    endtask

    function automatic logic [3:0] expect_at(input int c, input int n, input logic [31:0] bits, input logic dn);
        logic v;
        v = (c >= 1) && (c <= n);
        return {v, dn && (c == n + 1), v, v ? bits[n - c] : 1'b0};
    endfunction

    task automatic run_vec(input int k, input vec_t v);
        @(negedge clk);
        pattern = v.pattern;
        len     = v.len;
        rpt     = v.rpt;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        pattern = ~v.pattern;
        len     = ~v.len;
        rpt     = ~v.rpt;
        for (int c = 1; c <= v.exp_n + 3; c++) begin
            chk($sformatf("vec%0d", k), c, expect_at(c, v.exp_n, v.exp_bits, v.exp_done));
            stop = (c == v.stop_at);
            @(negedge clk);
        end
        stop = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 3'd7, 4'd0, -1, 8, 32'hA5,   1'b1};
        vecs[1] = '{8'h03, 3'd1, 4'd2, -1, 6, 32'h3F,   1'b1};
        vecs[2] = '{8'hFF, 3'd7, 4'd0,  3, 3, 32'h7,    1'b0};
        vecs[3] = '{8'h5A, 3'd3, 4'd1, -1, 8, 32'hAA,   1'b1};
        vecs[4] = '{8'h01, 3'd0, 4'd3, -1, 4, 32'hF,    1'b1};
        vecs[5] = '{8'h02, 3'd0, 4'd0, -1, 1, 32'h0,    1'b1};
        vecs[6] = '{8'h80, 3'd7, 4'd0, -1, 8, 32'h80,   1'b1};

        // reset held across edges with start high
        pattern = 8'hA5; len = 3'd7; start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_hold", 0, 4'b0000);
        start = 1'b0;
        reset_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("post_reset_idle", c, 4'b0000);
        end

        for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

        // start and stop together in IDLE: stop wins
        @(negedge clk);
        pattern = 8'hFF; len = 3'd7; rpt = 4'd0; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("start_stop_idle", c, 4'b0000);
            @(negedge clk);
        end

        // start re-pulsed mid-run and held through DONE; new inputs must not disturb the run
        pattern = 8'hA5; len = 3'd7; rpt = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            if (c <= 10) chk("restart_first", c, expect_at(c, 8, 32'hA5, 1'b1));
            else         chk("restart_second", c, expect_at(c - 10, 8, 32'h3C, 1'b1));
            if (c == 4) begin
                start = 1'b1;
                pattern = 8'h3C;
            end
            if (c == 11) start = 1'b0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // asynchronous reset in the middle of SHIFT
        pattern = 8'hFF; len = 3'd7; rpt = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_async", 3, 4'b1011);
        #2 reset_n = 1'b0;
        #1 chk("async_clear", 3, 4'b0000);
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk);
            chk("async_hold", c, 4'b0000);
        end
        reset_n = 1'b1;
        for (int c = 7; c <= 12; c++) begin
            @(negedge clk);
            chk("async_no_done", c, 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter WIDTH, default 8, is the pattern register width in bits and SHALL be a power of two, 2..32.
REQ-002 Parameter RPT_W, default 4, is the repeat-count width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 stop  input  1  abort the transmission in progress.
REQ-007 pattern  input  WIDTH  bit pattern to emit; captured on an accepted start.
REQ-008 len  input  clog2(WIDTH)  number of bits per pass minus one (0 means 1 bit); captured on an accepted start.
REQ-009 rpt  input  RPT_W  number of extra passes (0 means a single pass); captured on an accepted start.
REQ-010 out  output  1  serial bit, registered.
REQ-011 out_valid  output  1  high when out carries a pattern bit, registered.
REQ-012 busy  output  1  high while in SHIFT, registered.
REQ-013 done  output  1  one-cycle pulse when a transmission completes normally, registered.

Function
REQ-014 The controller SHALL be a Moore FSM with states IDLE, SHIFT and DONE; every output SHALL be a function of registered state only, with no combinational path from any input to any output.
REQ-015 In IDLE, start=1 with stop=0 SHALL capture pattern, len and rpt, load bit index = len and pass count = rpt, and transition to SHIFT.
REQ-016 In SHIFT: out = captured_pattern[bit index], out_valid=1, busy=1; the bit index SHALL decrement each cycle, giving MSB-first order within the len+1 field.
REQ-017 When the bit index reaches 0 and the pass count is nonzero, the block SHALL reload the bit index to len, decrement the pass count and stay in SHIFT with no idle cycle between passes.
REQ-018 When the bit index reaches 0 and the pass count is 0, the next state SHALL be DONE.
REQ-019 Total out_valid cycles per transmission SHALL equal (len+1)*(rpt+1).
REQ-020 The first valid bit SHALL appear in the cycle immediately after start is sampled (latency 1).
REQ-021 DONE SHALL last exactly one cycle with done=1, out_valid=0, out=0 and busy=0, then return to IDLE.
REQ-022 In IDLE and DONE, out and out_valid SHALL be 0.
REQ-023 start SHALL be ignored in SHIFT and DONE; a start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-024 stop=1 in SHIFT SHALL move the FSM to IDLE on the next edge with no done pulse; out_valid SHALL be 0 from that cycle.
REQ-025 stop=1 together with start=1 in IDLE SHALL leave the FSM in IDLE (stop wins).
REQ-026 The captured pattern, len and rpt SHALL hold constant during SHIFT regardless of input changes.

Reset
REQ-027 reset_n=0 SHALL immediately force state=IDLE, out=0, out_valid=0, busy=0, done=0, and clear the counters and the pattern register, independent of clk.
REQ-028 Assertion of reset_n mid-SHIFT SHALL abort the transmission with no done pulse.
REQ-029 After deassertion of reset_n, the first start SHALL be sampled on the first rising clk edge.

Structure
REQ-030 The state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default WIDTH/RPT_W SHALL live in shared package seq_pkg.
REQ-031 The block SHALL be a single module with no sub-module; the bit-index and pass counters SHALL be inline registers.
REQ-032 The unused state encoding 2'b11 SHALL recover to IDLE.

Verification
REQ-033 Reset: hold reset_n=0 across an edge with start=1 -> out, out_valid, busy and done all 0; no transmission follows the release of reset_n.
REQ-034 pattern=8'hA5, len=7, rpt=0, start pulsed at cycle 0 -> out 1,0,1,0,0,1,0,1 with out_valid=1 in cycles 1-8; done=1 in cycle 9 only.
REQ-035 pattern=8'h03, len=1, rpt=2 -> out 1,1,1,1,1,1 with out_valid=1 in cycles 1-6 and no gap between passes; done in cycle 7.
REQ-036 pattern=8'hFF, len=7, stop=1 in cycle 3 -> out_valid=0 from cycle 4; done stays 0; busy=0 from cycle 4.
REQ-037 Re-pulse start at cycle 4 of a len=7 run -> start ignored, bit sequence unchanged; start held high through DONE -> new run begins 1 cycle after DONE.
REQ-038 Assert reset_n=0 asynchronously mid-cycle during SHIFT -> outputs clear before the next clk edge; no done pulse follows.
